// File: rtl/counter_updown_param.sv
// counter_updown_param
//   Up/down modulo counter (range 0..MAX_COUNT) advanced by an internal
//   prescaler tick. Everything runs in the single clk domain.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   en        count enable; gates both the prescaler and counting
//   up_dn     direction, 1 = up, 0 = down (sampled on step edges only)
//   sat       boundary mode, 1 = saturate, 0 = wrap (sampled on step edges only)
//   load      synchronous load strobe; has priority over a step
//   load_val  value to load, clamped to MAX_COUNT
//   out       current count (registered)
//   tick      combinational prescaler terminal, en && (pre == DIV-1)
//   tc        registered one-cycle terminal-count pulse
module counter_updown_param #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int DIV       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  logic             at_bound;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;

  // Prescaler. With DIV=1 there is no register at all and every enabled
  // cycle is a tick.
  generate
    if (DIV == 1) begin : g_no_pre
      assign tick = en;
    end else begin : g_pre
      localparam int            PW       = $clog2(DIV);
      localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

      logic [PW-1:0] pre;

      assign tick = en && (pre == PRE_LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pre <= '0;
        end else if (load) begin
          pre <= '0;
        end else if (en) begin
          pre <= tick ? '0 : pre + PW'(1);
        end
      end
    end
  endgenerate

  // When MAX_COUNT fills the whole register the clamp can never trigger,
  // so the comparison is left out rather than being a constant compare.
  generate
    if (MAX_COUNT < (2 ** WIDTH) - 1) begin : g_clamp
      assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
    end else begin : g_no_clamp
      assign load_clamped = load_val;
    end
  endgenerate

  // Next value for a step. Boundaries are handled explicitly so the
  // modulus is MAX_COUNT+1 rather than the natural 2^WIDTH wrap.
  always_comb begin
    at_bound = up_dn ? (out == MAX_V) : (out == '0);
    step_val = out;
    if (up_dn) begin
      step_val = at_bound ? (sat ? out : '0) : out + WIDTH'(1);
    end else begin
      step_val = at_bound ? (sat ? out : MAX_V) : out - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      out <= load_clamped;
      tc  <= 1'b0;
    end else if (tick) begin
      out <= step_val;
      tc  <= at_bound;
    end else begin
      tc  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_updown_param.sv
module tb_counter_updown_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, sat, load;
  logic [3:0] load_val;
  logic [3:0] out_a, out_b;
  logic       tick_a, tick_b, tc_a, tc_b;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit    sel;    // 0 = main instance (MAX 9, DIV 4), 1 = DIV 1 / MAX 15
    bit    xtick;  // expected tick during the cycle, before the edge
    int    xout;   // expected out after the edge
    bit    xtc;    // expected tc after the edge
    string nm;
  } item_t;

  item_t sb[$];

  counter_updown_param #(.WIDTH(4), .MAX_COUNT(9), .DIV(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val), .out(out_a), .tick(tick_a), .tc(tc_a)
  );

  counter_updown_param #(.WIDTH(4), .MAX_COUNT(15), .DIV(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val), .out(out_b), .tick(tick_b), .tc(tc_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle, checks tick mid-cycle and the
  // registered outputs just after the following rising edge.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        chk({it.nm, " tick"}, it.sel ? int'(tick_b) : int'(tick_a), int'(it.xtick));
        @(posedge clk);
        #1;
        chk({it.nm, " out"}, it.sel ? int'(out_b) : int'(out_a), it.xout);
        chk({it.nm, " tc"},  it.sel ? int'(tc_b)  : int'(tc_a),  int'(it.xtc));
        n_vec++;
      end
    end
  end

  // Called at a falling edge: drive inputs, queue the expectation, advance.
  task automatic vec(input bit sel, input bit e, input bit u, input bit s,
                     input bit l, input int lv, input bit xtick, input int xout,
                     input bit xtc, input string nm);
    en = e; up_dn = u; sat = s; load = l; load_val = 4'(lv);
    sb.push_back('{sel: sel, xtick: xtick, xout: xout, xtc: xtc, nm: nm});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 0; up_dn = 1; sat = 0; load = 0; load_val = '0;
    #1;
    chk("reset out", int'(out_a), 0);
    chk("reset tc", int'(tc_a), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: up, wrap, 44 cycles: 0..9,0 stepping every 4 clocks
    for (int k = 0; k < 44; k++)
      vec(0, 1, 1, 0, 0, 0, (k % 4) == 3, ((k + 1) / 4) % 10, k == 39, "s1");

    // 2: load 0, count down with wrap: 9 (tc), 8, 7
    vec(0, 0, 0, 0, 1, 0, 0, 0, 0, "s2 load");
    for (int k = 0; k < 12; k++)
      vec(0, 1, 0, 0, 0, 0, (k % 4) == 3,
          (k < 3) ? 0 : (k < 7) ? 9 : (k < 11) ? 8 : 7, k == 3, "s2");

    // 3: load 12 clamps to 9, then saturate up: stays 9, tc on every tick
    vec(0, 0, 1, 1, 1, 12, 0, 9, 0, "s3 load clamp");
    for (int k = 0; k < 12; k++)
      vec(0, 1, 1, 1, 0, 0, (k % 4) == 3, 9, (k % 4) == 3, "s3 sat");

    // 4: load 5 on a tick cycle; the 9->0 wrap and its tc are discarded
    for (int k = 0; k < 3; k++)
      vec(0, 1, 1, 0, 0, 0, 0, 9, 0, "s4 pre");
    vec(0, 1, 1, 0, 1, 5, 1, 5, 0, "s4 load on tick");
    for (int k = 0; k < 4; k++)
      vec(0, 1, 1, 0, 0, 0, k == 3, (k == 3) ? 6 : 5, 0, "s4 after");

    // 6: mid-count async reset at out=6 (pre=2)
    vec(0, 1, 1, 0, 0, 0, 0, 6, 0, "s6 pre");
    vec(0, 1, 1, 0, 0, 0, 0, 6, 0, "s6 pre");
    #3;
    rst = 1'b1;
    #1;
    chk("s6 async out", int'(out_a), 0);
    chk("s6 async tc", int'(tc_a), 0);
    chk("s6 async tick", int'(tick_a), 0);
    @(negedge clk);
    chk("s6 held out", int'(out_a), 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++)
      vec(0, 1, 1, 0, 0, 0, k == 3, (k == 3) ? 1 : 0, 0, "s6 resume");

    // 5: 2 enabled, 5 disabled, then step after 2 more enabled cycles
    for (int k = 0; k < 2; k++) vec(0, 1, 1, 0, 0, 0, 0, 1, 0, "s5 en");
    for (int k = 0; k < 5; k++) vec(0, 0, 1, 0, 0, 0, 0, 1, 0, "s5 hold");
    vec(0, 1, 1, 0, 0, 0, 0, 1, 0, "s5 en2");
    vec(0, 1, 1, 0, 0, 0, 1, 2, 0, "s5 step");

    // 7: DIV=1, MAX_COUNT=15 instance, steps every cycle, wraps with tc
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++)
      vec(1, 1, 1, 0, 0, 0, 1, (k + 1) % 16, k == 15, "s7");

    en = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_updown_param.md
Name: counter_updown_param

Overview:
Parametrised up/down modulo counter for the lab datapath. It is the successor to the fixed 4-bit divided-clock counter. Instead of a derived clock, an internal prescaler generates a single-cycle count-enable tick, so the whole block runs in one clock domain. It adds width and modulus parameters, direction control, synchronous load, a wrap/saturate mode and a terminal-count pulse.

Parameters:
WIDTH, 4, counter width in bits (>=1)
MAX_COUNT, 15, highest count value; legal range 0..2^WIDTH-1; count range is 0..MAX_COUNT
DIV, 4, prescaler ratio; a count step occurs every DIV enabled cycles; DIV=1 steps every enabled cycle

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  count enable; gates prescaler and counting
up_dn  in  1  direction: 1=up, 0=down
sat  in  1  boundary mode: 1=saturate, 0=wrap
load  in  1  synchronous load strobe
load_val  in  WIDTH  value to load
out  out  WIDTH  current count (registered)
tick  out  1  combinational prescaler terminal: en && (pre == DIV-1)
tc  out  1  registered terminal-count pulse

Behaviour:
- Reset (async, rst=1): out=0, prescaler pre=0, tc=0, immediately with no clock edge. Held while rst=1.
- Prescaler: pre is a ceil(log2(DIV))-bit register; for DIV=1 it is a constant 0 and tick=en.
  - en=1 and pre<DIV-1: pre+1.
  - en=1 and pre==DIV-1: pre becomes 0 and tick=1 that cycle.
  - en=0: pre holds; tick=0.
- Priority per rising edge: rst > load > tick-step > hold.
- Load: on an edge with load=1, out=min(load_val, MAX_COUNT), pre=0, tc=0.
  - Applies regardless of en and tick.
  - A coincident tick is discarded.
- Step (edge with tick=1, load=0):
  - up_dn=1, out<MAX_COUNT: out+1.
  - up_dn=1, out==MAX_COUNT: wrap mode -> 0; sat mode -> hold at MAX_COUNT.
  - up_dn=0, out>0: out-1.
  - up_dn=0, out==0: wrap mode -> MAX_COUNT; sat mode -> hold at 0.
- Arithmetic is WIDTH bits and never relies on natural 2^WIDTH overflow; the modulus is MAX_COUNT+1.
- tc: set to 1 on an edge where a step occurs with out at the boundary in the counting direction (MAX_COUNT when up, 0 when down), in either mode. Cleared on every other edge, so it is exactly one clk wide.
  - In sat mode with a persistent boundary, tc pulses once per tick.
- up_dn and sat are sampled only on step edges; changing them between ticks has no other effect.
- Edge case MAX_COUNT=0: out is always 0 and tc pulses on every step.
- No combinational path from inputs to out or tc. tick is the only combinational output.

Test Plan:
Bench configuration is WIDTH=4, MAX_COUNT=9, DIV=4 unless stated.
1. Reset, then en=1, up_dn=1, sat=0 for 44 cycles -> out steps every 4 clk: 0,1,...,9,0. tc high for exactly one cycle, the first cycle out==0 after 9. tick high every 4th cycle.
2. load=1 with load_val=0, then up_dn=0, sat=0, en=1 -> first step gives out=9 with a tc pulse, then 8,7 on the next ticks.
3. load_val=12 with load=1 -> out=9 (clamped). Then sat=1, up_dn=1 for 3 ticks -> out stays 9 and tc pulses on each of the 3 ticks.
4. Assert load (load_val=5) in the same cycle tick=1 -> out=5 (no step applied) and pre=0. The next step occurs 4 enabled cycles later.
5. en=1 for 2 cycles, en=0 for 5 cycles, en=1 again -> the step occurs after 2 more enabled cycles; out is unchanged during en=0.
6. Counting at out=6, assert rst between clock edges -> out=0 and tc=0 immediately. After deassertion, counting resumes from 0 with a full DIV-cycle prescale.
7. Rerun scenario 1 with DIV=1, MAX_COUNT=15 -> out steps every cycle and wraps 15->0 with a tc pulse.
